// File: rtl/sensor_conditioner_if.sv
// Bundle of the raw sensor pins and the conditioned sensor outputs.
// master = the conditioner that produces sensor_clean; slave = the consumer that also drives the raw pins.
interface sensor_conditioner_if;
  logic [3:0] sensor_raw;
  logic [3:0] sensor_clean;
  logic       sample_valid;
  logic       changed;
  logic       line_lost;
  logic [1:0] last_side;

  // sample_valid is a valid-only strobe: there is no ready, the consumer must take
  // sensor_clean/changed/line_lost/last_side in the single cycle sample_valid is high.
  modport master (
    input  sensor_raw,
    output sensor_clean, sample_valid, changed, line_lost, last_side
  );

  modport slave (
    output sensor_raw,
    input  sensor_clean, sample_valid, changed, line_lost, last_side
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Synchronizes, tick-samples and debounces four IR line sensors; reports line loss and last side.
// Optional lost-line/last-side tracker is built only when SENSOR_LOST_LINE_EN is defined.
module sensor_conditioner #(
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 8,
  parameter int LOST_TICKS = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  sensor_conditioner_if.master bus
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(STABLE_CNT) + 1;
  localparam logic [TW-1:0] TCNT_MAX = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DCNT_MAX = DW'(STABLE_CNT - 1);

  logic [3:0]    sync1, sync2;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic [DW-1:0] dcnt      [4];
  logic [DW-1:0] dcnt_next [4];
  logic [3:0]    clean_q, clean_next;
  logic          valid_q, changed_q;

  assign tick = (tcnt == TCNT_MAX);

  // A single sample agreeing with the current output restarts that channel's count.
  always_comb begin
    clean_next = clean_q;
    for (int i = 0; i < 4; i++) begin
      dcnt_next[i] = dcnt[i];
      if (tick) begin
        if (sync2[i] == clean_q[i]) begin
          dcnt_next[i] = '0;
        end else if (dcnt[i] == DCNT_MAX) begin
          clean_next[i] = sync2[i];
          dcnt_next[i]  = '0;
        end else begin
          dcnt_next[i] = dcnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      tcnt      <= '0;
      clean_q   <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      for (int i = 0; i < 4; i++) dcnt[i] <= '0;
    end else begin
      sync1     <= bus.sensor_raw;
      sync2     <= sync1;
      tcnt      <= tick ? '0 : tcnt + TW'(1);
      clean_q   <= clean_next;
      valid_q   <= tick;
      changed_q <= (clean_next != clean_q);
      for (int i = 0; i < 4; i++) dcnt[i] <= dcnt_next[i];
    end
  end

  assign bus.sensor_clean = clean_q;
  assign bus.sample_valid = valid_q;
  assign bus.changed      = changed_q;

`ifdef SENSOR_LOST_LINE_EN
  localparam int LW = $clog2(LOST_TICKS + 1);
  localparam logic [LW-1:0] LCNT_MAX = LW'(LOST_TICKS);

  logic [LW-1:0] lcnt, lcnt_next;
  logic [1:0]    side_q, side_next;
  logic          lost_q;

  // Both trackers look at the vector as it stands after this tick's debounce update.
  always_comb begin
    lcnt_next = lcnt;
    side_next = side_q;
    if (tick) begin
      if (clean_next == 4'b0000) begin
        if (lcnt != LCNT_MAX) lcnt_next = lcnt + LW'(1);
      end else begin
        lcnt_next = '0;
      end
      if (clean_next[0] && !clean_next[3])      side_next = 2'b01;
      else if (clean_next[3] && !clean_next[0]) side_next = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt   <= '0;
      side_q <= 2'b00;
      lost_q <= 1'b0;
    end else begin
      lcnt   <= lcnt_next;
      side_q <= side_next;
      lost_q <= (lcnt_next == LCNT_MAX);
    end
  end

  assign bus.line_lost = lost_q;
  assign bus.last_side = side_q;
`else
  assign bus.line_lost = 1'b0;
  assign bus.last_side = 2'b00;
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: a cycle model feeds a scoreboard queue, plus directed latency checks.
module tb_sensor_conditioner;
  localparam int TD = 4;
  localparam int SC = 3;
  localparam int LT = 5;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  sensor_conditioner_if bus ();

  sensor_conditioner #(.TICK_DIV(TD), .STABLE_CNT(SC), .LOST_TICKS(LT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check task ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Expected entry = {clean[3:0], changed, line_lost, last_side[1:0]}
  logic [7:0] exp_q[$];
  logic [3:0] m_s1 = '0, m_s2 = '0, m_clean = '0;
  int         m_tcnt = 0, m_lcnt = 0;
  int         m_dcnt [4] = '{0, 0, 0, 0};
  logic       m_valid = 1'b0, m_changed = 1'b0, m_lost = 1'b0;
  logic [1:0] m_side = 2'b00;

  always @(posedge clk) begin
    logic m_tick;
    logic [3:0] old_clean;
    m_tick = (m_tcnt == TD - 1);
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_tcnt = 0; m_lcnt = 0;
      for (int i = 0; i < 4; i++) m_dcnt[i] = 0;
      m_valid = 1'b0; m_changed = 1'b0; m_lost = 1'b0; m_side = 2'b00;
      exp_q.delete();
    end else begin
      m_valid   = m_tick;
      m_changed = 1'b0;
      if (m_tick) begin
        old_clean = m_clean;
        for (int i = 0; i < 4; i++) begin
          if (m_s2[i] == old_clean[i]) m_dcnt[i] = 0;
          else if (m_dcnt[i] == SC - 1) begin
            m_clean[i] = m_s2[i];
            m_dcnt[i]  = 0;
          end else m_dcnt[i] = m_dcnt[i] + 1;
        end
        m_changed = (m_clean != old_clean);
`ifdef SENSOR_LOST_LINE_EN
        if (m_clean == 4'b0000) m_lcnt = (m_lcnt < LT) ? m_lcnt + 1 : LT;
        else                    m_lcnt = 0;
        m_lost = (m_lcnt == LT);
        if (m_clean[0] && !m_clean[3])      m_side = 2'b01;
        else if (m_clean[3] && !m_clean[0]) m_side = 2'b10;
`endif
        exp_q.push_back({m_clean, m_changed, m_lost, m_side});
      end
      m_tcnt = m_tick ? 0 : m_tcnt + 1;
      m_s2 = m_s1;
      m_s1 = bus.sensor_raw;
    end
  end

  // Per-cycle monitor on the falling edge.
  always @(negedge clk) begin
    logic [7:0] e;
    check("sample_valid", 32'(bus.sample_valid), 32'(m_valid));
    check("sensor_clean", 32'(bus.sensor_clean), 32'(m_clean));
    check("line_lost",    32'(bus.line_lost),    32'(m_lost));
    check("last_side",    32'(bus.last_side),    32'(m_side));
    if (bus.sample_valid) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("sb_sample", 32'({bus.sensor_clean, bus.changed, bus.line_lost, bus.last_side}), 32'(e));
      end
    end else begin
      check("changed_idle", 32'(bus.changed), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [3:0] v);
    bus.sensor_raw = v;
  endtask

  // Cycles until the next sample_valid (bounded).
  task automatic gap_to_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.sample_valid && n < 50);
    if (!bus.sample_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  // Number of sample_valid pulses up to and including the first one with changed.
  task automatic valids_to_change(output int n);
    int cyc = 0;
    n = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.sample_valid) begin
        n++;
        if (bus.changed) break;
      end
    end
    if (cyc >= 200) begin
      check("change_timeout", 32'd0, 32'd1);
      n = -1;
    end
  endtask

  // Run a number of sample_valid pulses, counting changed pulses.
  task automatic run_valids(input int nv, output int nch);
    int seen = 0, cyc = 0;
    nch = 0;
    while (seen < nv && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.sample_valid) begin
        seen++;
        if (bus.changed) nch++;
      end
    end
    if (seen < nv) check("run_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, nch, nch2, k;
    logic [1:0] side_l, side_r;
`ifdef SENSOR_LOST_LINE_EN
    side_l = 2'b01; side_r = 2'b10;
`else
    side_l = 2'b00; side_r = 2'b00;
`endif
    rst = 1'b1;
    apply(4'b1111);
    repeat (5) @(negedge clk);
    check("rst_clean",   32'(bus.sensor_clean), 32'h0);
    check("rst_valid",   32'(bus.sample_valid), 32'h0);
    check("rst_changed", 32'(bus.changed),      32'h0);
    check("rst_lost",    32'(bus.line_lost),    32'h0);
    check("rst_side",    32'(bus.last_side),    32'h0);

    apply(4'b0000);
    rst = 1'b0;
    gap_to_valid(n);
    check("first_valid_gap", 32'(n), 32'd4);
    gap_to_valid(n);
    check("valid_period", 32'(n), 32'd4);

    // Debounce accept: flip on the 3rd sample after the step.
    apply(4'b0010);
    valids_to_change(n);
    check("accept_latency", 32'(n), 32'd3);
    check("accept_clean", 32'(bus.sensor_clean), 32'h2);

    apply(4'b0000);
    valids_to_change(n);
    check("release_latency", 32'(n), 32'd3);

    // Glitch of two ticks is rejected.
    apply(4'b0010);
    run_valids(2, nch);
    apply(4'b0000);
    run_valids(6, nch2);
    check("glitch_changed", 32'(nch + nch2), 32'd0);
    check("glitch_clean", 32'(bus.sensor_clean), 32'h0);

    // Last side tracking.
    apply(4'b0001);
    valids_to_change(n);
    check("side_left", 32'(bus.last_side), 32'(side_l));
    apply(4'b0110);
    valids_to_change(n);
    check("side_hold_centre", 32'(bus.last_side), 32'(side_l));
    check("multi_flip_clean", 32'(bus.sensor_clean), 32'h6);
    apply(4'b1000);
    valids_to_change(n);
    check("side_right", 32'(bus.last_side), 32'(side_r));

    // Line lost: the flip tick is the first all-zero tick, LT zero ticks assert it.
    apply(4'b0000);
    valids_to_change(n);
    check("lost_clean_zero", 32'(bus.sensor_clean), 32'h0);
    check("lost_not_yet", 32'(bus.line_lost), 32'd0);
`ifdef SENSOR_LOST_LINE_EN
    k = 1;
    while (!bus.line_lost && k < 12) begin
      gap_to_valid(n);
      k++;
    end
    check("lost_ticks", 32'(k), 32'(LT));
    check("lost_side_hold", 32'(bus.last_side), 32'h2);
    run_valids(3, nch);
    check("lost_stays", 32'(bus.line_lost), 32'd1);
`else
    run_valids(8, nch);
    check("lost_tied_low", 32'(bus.line_lost), 32'd0);
`endif
    apply(4'b0100);
    valids_to_change(n);
    check("regain_clean", 32'(bus.sensor_clean), 32'h4);
    check("regain_lost", 32'(bus.line_lost), 32'd0);

    // Reset mid-debounce: two differing ticks, then reset restarts everything.
    apply(4'b0001);
    run_valids(2, nch);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_clean", 32'(bus.sensor_clean), 32'h0);
    check("midrst_side",  32'(bus.last_side),    32'h0);
    rst = 1'b0;
    valids_to_change(n);
    check("midrst_fresh_ticks", 32'(n), 32'd3);
    check("midrst_clean_after", 32'(bus.sensor_clean), 32'h1);

    repeat (6) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
